// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared state type, byte width and counter sizing for wide_add_seq
package wide_add_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/adder8bit.sv
// adder8bit: 8-bit ripple-carry adder used as the shared byte datapath
module adder8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic c;
  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: byte-serial NBYTES-wide adder over one adder8bit; WIDE_ADD_SEQ_SUB_EN adds op_sub
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BYTE_W*NBYTES-1:0]   a,
  input  logic [BYTE_W*NBYTES-1:0]   b,
  input  logic                       cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic                       op_sub,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [BYTE_W*NBYTES-1:0]   s,
  output logic                       cout,
  output logic                       ovf
);
  localparam int W  = BYTE_W * NBYTES;
  localparam int CW = cnt_width(NBYTES);
  state_t          state;
  logic [W-1:0]    a_r, b_r, s_r, s_fin;
  logic            c_r, sub, co;
  logic [CW-1:0]   cnt;
  logic [BYTE_W-1:0] a_sel, b_sel, sum;
  logic            last;
`ifdef WIDE_ADD_SEQ_SUB_EN
  assign sub = op_sub;
`else
  assign sub = 1'b0;
`endif
  assign a_sel = a_r[BYTE_W*cnt +: BYTE_W];
  assign b_sel = b_r[BYTE_W*cnt +: BYTE_W];
  assign last  = cnt == CW'(NBYTES - 1);
  adder8bit u_add (.a(a_sel), .b(b_sel), .cin(c_r), .s(sum), .cout(co));
  // final result merges the byte being written this cycle so s never lags s_r
  always_comb begin
    s_fin = s_r;
    s_fin[BYTE_W*cnt +: BYTE_W] = sum;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      c_r   <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            c_r   <= sub | cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          s_r[BYTE_W*cnt +: BYTE_W] <= sum;
          c_r <= co;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            s     <= s_fin;
            cout  <= co;
            ovf   <= (a_r[W-1] == b_r[W-1]) && (sum[BYTE_W-1] != a_r[W-1]);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
